// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFOs, run-time CPOL/CPHA/LSB-first and a 3-bit register window.
// Queued words stream back-to-back under one slave select; irq is a registered masked status level.
module spi_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;

  assign pop_dat = mem_q[rptr_q[AW-1:0]];
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // A push into a full FIFO is only issued alongside a pop; the popped word is read before this write lands.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= push_dat;
  end
endmodule

module spi_master_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  irq,
  input  logic                  MISO,
  output logic                  MOSI,
  output logic                  SCLK,
  output logic [NUM_SLAVES-1:0] SS_n
);
  localparam int EW = $clog2(2 * DATA_WIDTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d, divl_q, divl_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, rx_q, rx_d;
  logic                  cpha_q, cpha_d, lsb_q, lsb_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d, ssel_q, ssel_d, ss_n_q, ss_n_d;
  logic [7:0]            ctrl_q, ctrl_d;
  logic                  toe_q, toe_d, roe_q, roe_d, push_q, push_d;
  logic                  sclk_q, sclk_d, mosi_q, mosi_d, irq_q, irq_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  wr, rd, tick, load;
  logic                  tx_push, tx_empty, tx_full, rx_push, rx_pop, rx_empty, rx_full;
  logic [DATA_WIDTH-1:0] tx_dat, rx_dat;
  logic [5:0]            status;
  logic                  unused_ok;

  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shl(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign wr        = chipselect && write;
  assign rd        = chipselect && read;
  assign tick      = (state_q != IDLE) && (cnt_q == divl_q);
  assign load      = !tx_empty && ((state_q == IDLE) || ((state_q == TRAIL) && tick));
  assign tx_push   = wr && (address == 3'd1) && !tx_full;
  assign rx_pop    = rd && (address == 3'd0) && !rx_empty;
  // A pop in the same cycle frees the slot, so a push into a full RX is then not an overflow.
  assign rx_push   = push_q && (!rx_full || rx_pop);
  assign status    = {toe_q || roe_q, roe_q, toe_q, tx_empty && (state_q == IDLE), !tx_full, !rx_empty};
  assign unused_ok = ^writedata;

  spi_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(reset), .push(tx_push), .push_dat(writedata[DATA_WIDTH-1:0]),
    .pop(load), .pop_dat(tx_dat), .empty(tx_empty), .full(tx_full)
  );

  spi_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(reset), .push(rx_push), .push_dat(rx_q),
    .pop(rx_pop), .pop_dat(rx_dat), .empty(rx_empty), .full(rx_full)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    divl_d  = divl_q;
    sel_d   = sel_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    push_d  = 1'b0;
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    ssel_d  = ssel_q;
    rdata_d = rdata_q;
    ss_n_d  = '1;

    if (wr) begin
      case (address)
        3'd3:    ctrl_d = writedata[7:0];
        3'd4:    div_d  = writedata[DIV_WIDTH-1:0];
        3'd5:    ssel_d = writedata[NUM_SLAVES-1:0];
        default: ;
      endcase
    end
    toe_d = (toe_q && !(wr && (address == 3'd2) && writedata[3])) || (wr && (address == 3'd1) && tx_full);
    roe_d = (roe_q && !(wr && (address == 3'd2) && writedata[4])) || (push_q && rx_full && !rx_pop);

    if (rd) begin
      case (address)
        3'd0:    rdata_d = rx_empty ? '0 : 32'(rx_dat);
        3'd2:    rdata_d = 32'(status);
        3'd3:    rdata_d = 32'(ctrl_q);
        3'd4:    rdata_d = 32'(div_q);
        3'd5:    rdata_d = 32'(ssel_q);
        default: rdata_d = '0;
      endcase
    end
    irq_d = |({status[5], status[2:0]} & ctrl_q[7:4]);

    if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE:  sclk_d = ctrl_q[0];
      LEAD:  if (tick) state_d = SHIFT;
      SHIFT: if (tick) begin
        sclk_d = ~sclk_q;
        edge_d = edge_q + 1'b1;
        // Even edge_q is a leading edge; CPHA selects which edge samples and which shifts.
        if (edge_q[0] == cpha_q) begin
          rx_d = lsb_q ? {MISO, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], MISO};
        end else if (cpha_q) begin
          mosi_d = out_bit(sh_q, lsb_q);
          sh_d   = shl(sh_q, lsb_q);
        end else begin
          mosi_d = out_bit(shl(sh_q, lsb_q), lsb_q);
          sh_d   = shl(sh_q, lsb_q);
        end
        if (edge_q == LAST_EDGE) begin
          state_d = TRAIL;
          push_d  = 1'b1;
        end
      end
      TRAIL: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = (state_q == IDLE) ? LEAD : SHIFT;
      cnt_d   = '0;
      edge_d  = '0;
      sh_d    = tx_dat;
      cpha_d  = ctrl_q[1];
      lsb_d   = ctrl_q[2];
      divl_d  = div_q;
      sel_d   = ssel_q;
      if (!ctrl_q[1]) mosi_d = out_bit(tx_dat, ctrl_q[2]);
    end

    if (state_d != IDLE)  ss_n_d = ~sel_d;
    else if (ctrl_q[3])   ss_n_d = ~ssel_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      divl_q  <= '0;
      sel_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      push_q  <= 1'b0;
      ctrl_q  <= '0;
      div_q   <= '0;
      ssel_q  <= NUM_SLAVES'(1);
      toe_q   <= 1'b0;
      roe_q   <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
      ss_n_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      divl_q  <= divl_d;
      sel_q   <= sel_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      push_q  <= push_d;
      ctrl_q  <= ctrl_d;
      div_q   <= div_d;
      ssel_q  <= ssel_d;
      toe_q   <= toe_d;
      roe_q   <= roe_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
      ss_n_q  <= ss_n_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;
  assign MOSI     = mosi_q;
  assign SCLK     = sclk_q;
  assign SS_n     = ss_n_q;
endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: loopback and echoing-slave transfers, streaming,
// TX/RX overflow and mid-transfer reset, with hand-computed expectations.
module tb_spi_master_fifo;
  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect, read, write;
  logic [31:0]   writedata, readdata;
  logic          irq, MISO, MOSI, SCLK;
  logic [NS-1:0] SS_n;

  int n_cmp = 0;
  int n_bad = 0;

  logic       loop, tb_cpha, tb_lsb, sl_bit, sl_prev;
  logic [7:0] sl_word, mos_cap;
  logic [2:0] sl_i;
  int         sl_edges, sl_k, ss_cnt, ss_rise;
  logic [NS-1:0] ss_val;

  spi_master_fifo #(.DATA_WIDTH(8), .NUM_SLAVES(NS), .FIFO_DEPTH(4), .DIV_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .irq(irq), .MISO(MISO), .MOSI(MOSI), .SCLK(SCLK), .SS_n(SS_n)
  );

  always #5 clk = ~clk;

  assign MISO = loop ? MOSI : sl_bit;

  // Slave model: changes its output on the edge opposite the master's sampling edge.
  always @(SCLK or SS_n) begin
    if (SS_n[0] !== 1'b0) sl_edges = 0;
    else if (SCLK !== sl_prev) sl_edges++;
    sl_prev = SCLK;
  end

  always_comb begin
    sl_k = tb_cpha ? ((sl_edges == 0) ? 0 : (sl_edges - 1) / 2) : sl_edges / 2;
    sl_i = 3'(sl_k % 8);
    sl_bit = tb_lsb ? sl_word[sl_i] : sl_word[3'd7 - sl_i];
  end

  initial begin
    ss_cnt = 0;
    ss_rise = 0;
    ss_val = '1;
    mos_cap = '0;
  end
  always @(negedge clk) if (SS_n !== '1) begin ss_cnt++; ss_val = SS_n; end
  always @(posedge SS_n[0]) ss_rise++;
  always @(posedge SCLK) mos_cap = {mos_cap[6:0], MOSI};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_tmt(input string tag);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      bus_rd(3'd2, s);
      n++;
    end while (!s[2] && n < 600);
    chk(tag, 32'(s[2]), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    int base, rbase, n;
    logic [7:0] words [4];

    reset = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = '0; loop = 1'b1; tb_cpha = 1'b0; tb_lsb = 1'b0; sl_word = '0;
    #3 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_ss_n", 32'(SS_n), 32'h3);
    chk("rst_sclk", 32'(SCLK), 32'd0);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    bus_rd(3'd2, r); chk("rst_status", r, 32'h06);
    bus_rd(3'd5, r); chk("rst_slavesel", r, 32'h1);
    bus_rd(3'd4, r); chk("rst_clkdiv", r, 32'h0);
    bus_rd(3'd3, r); chk("rst_control", r, 32'h0);
    bus_rd(3'd7, r); chk("reg7_zero", r, 32'h0);

    // Mode 0 MSB-first loopback of 0xA5.
    bus_wr(3'd4, 32'd1);
    base = ss_cnt;
    bus_wr(3'd1, 32'hA5);
    wait_tmt("m0_tmt_wait");
    chk("m0_ss_cycles", 32'(ss_cnt - base), 32'd36);
    chk("m0_ss_value", 32'(ss_val), 32'h2);
    chk("m0_mosi_seq", 32'(mos_cap), 32'hA5);
    bus_rd(3'd2, r); chk("m0_status", r, 32'h07);
    bus_rd(3'd0, r); chk("m0_rxdata", r, 32'hA5);
    bus_rd(3'd0, r); chk("m0_rx_empty_read", r, 32'h0);
    bus_rd(3'd2, r); chk("m0_status_after", r, 32'h06);

    // Modes 1..3, LSB-first, slave echoes 0xC3 while master sends 0x3C.
    loop = 1'b0;
    sl_word = 8'hC3;
    tb_lsb = 1'b1;
    for (int m = 1; m < 4; m++) begin
      tb_cpha = m[1];
      bus_wr(3'd3, 32'(m) | 32'h4);
      repeat (2) @(negedge clk);
      chk($sformatf("mode%0d_sclk_idle", m), 32'(SCLK), 32'(m[0]));
      bus_wr(3'd1, 32'h3C);
      wait_tmt($sformatf("mode%0d_tmt_wait", m));
      bus_rd(3'd0, r); chk($sformatf("mode%0d_rx", m), r, 32'hC3);
      chk($sformatf("mode%0d_sclk_end", m), 32'(SCLK), 32'(m[0]));
    end

    // Four streamed words, irq on TMT.
    loop = 1'b1; tb_cpha = 1'b0; tb_lsb = 1'b0;
    bus_wr(3'd3, 32'h0);
    repeat (2) @(negedge clk);
    words[0] = 8'h81; words[1] = 8'h42; words[2] = 8'h3C; words[3] = 8'hE7;
    base = ss_cnt; rbase = ss_rise;
    for (int i = 0; i < 4; i++) bus_wr(3'd1, 32'(words[i]));
    bus_wr(3'd3, 32'h40);
    repeat (2) @(negedge clk);
    chk("stream_irq_busy", 32'(irq), 32'd0);
    n = 0;
    while (irq !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    chk("stream_irq_tmt", 32'(irq), 32'd1);
    chk("stream_ss_cycles", 32'(ss_cnt - base), 32'd138);
    chk("stream_ss_one_frame", 32'(ss_rise - rbase), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus_rd(3'd0, r); chk($sformatf("stream_rx%0d", i), r, 32'(words[i]));
    end
    bus_wr(3'd3, 32'h0);
    repeat (2) @(negedge clk);
    chk("irq_masked", 32'(irq), 32'd0);

    // Six fast writes: one loaded, four queued, one dropped; then RX overflows on the fifth word.
    base = ss_cnt;
    for (int i = 1; i <= 6; i++) bus_wr(3'd1, 32'(i));
    bus_rd(3'd2, r); chk("toe_status", r, 32'h28);
    bus_wr(3'd2, 32'h08);
    bus_rd(3'd2, r); chk("toe_cleared", r, 32'h00);
    wait_tmt("ovf_tmt_wait");
    chk("ovf_ss_cycles", 32'(ss_cnt - base), 32'd172);
    bus_rd(3'd2, r); chk("roe_status", r, 32'h37);
    for (int i = 1; i <= 4; i++) begin
      bus_rd(3'd0, r); chk($sformatf("ovf_rx%0d", i), r, 32'(i));
    end
    bus_rd(3'd0, r); chk("ovf_rx_empty", r, 32'h0);
    bus_wr(3'd2, 32'h10);
    bus_rd(3'd2, r); chk("roe_cleared", r, 32'h06);

    // Reset in the middle of a CPOL=1 transfer.
    bus_wr(3'd3, 32'h1);
    bus_wr(3'd1, 32'h5A);
    repeat (10) @(negedge clk);
    chk("pre_rst_active", 32'(SS_n), 32'h2);
    reset = 1'b1;
    #1;
    chk("midrst_ss_n", 32'(SS_n), 32'h3);
    chk("midrst_sclk", 32'(SCLK), 32'd0);
    chk("midrst_mosi", 32'(MOSI), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_rd(3'd3, r); chk("midrst_control", r, 32'h0);
    repeat (50) @(negedge clk);
    bus_rd(3'd2, r); chk("midrst_status", r, 32'h06);
    bus_rd(3'd0, r); chk("midrst_no_rx", r, 32'h0);
    chk("midrst_sclk_idle", 32'(SCLK), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
